ex_muldiv: RTL
==============

# ex_muldiv

Parametrised multiply/divide unit for the EX stage of the five-stage pipeline, sitting beside the ALU and sharing its forwarded operands. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and models fixed multi-cycle latencies with a countdown. It owns the HI/LO architectural registers and drives a busy/stall indication to the hazard unit, so dependent MFHI/MFLO and further mul/div operations are held in ID until the result commits.

## Interface
Parameters:
- WIDTH, 32: operand and HI/LO width.
- MUL_CYCLES, 5: busy cycles for MULT/MULTU (≥1).
- DIV_CYCLES, 10: busy cycles for DIV/DIVU (≥1).
- CNT_W, $clog2(max(MUL_CYCLES,DIV_CYCLES)+1): countdown width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low; low clears all state immediately.
- md_start  in  1  EX holds a valid mul/div/mt instruction this cycle.
- md_op  in  3  operation code (md_pkg): NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- src_a  in  WIDTH  forwarded rs value.
- src_b  in  WIDTH  forwarded rt value.
- md_busy  out  1  registered; high while an operation is in flight.
- md_stall  out  1  combinational; md_busy | (md_start & op is MULT/MULTU/DIV/DIVU).
- hi  out  WIDTH  registered HI.
- lo  out  WIDTH  registered LO.

## Operation
- Reset (reset low, async): hi=0, lo=0, md_busy=0, counter=0, pending HI/LO=0. md_stall then reduces to the start term.
- Accept: on a rising edge with md_start=1, md_busy=0:
  - MULT: pending {HI,LO} = signed src_a × signed src_b (2·WIDTH bits); counter = MUL_CYCLES; md_busy←1.
  - MULTU: unsigned product; same.
  - DIV: LO=quotient truncated toward zero, HI=remainder with sign of dividend; counter = DIV_CYCLES; md_busy←1.
  - DIVU: unsigned quotient/remainder; same.
  - DIV overflow (−2^(WIDTH−1) ÷ −1): LO=0x80000000, HI=0 (WIDTH=32).
  - Divide by zero (src_b=0): accepted, busy for DIV_CYCLES, HI/LO left unchanged at commit.
  - MTHI: hi←src_a at this edge; no busy. MTLO: lo←src_a likewise.
  - NONE: no effect.
- md_start while md_busy=1: protocol violation (hazard unit prevents it); ignored, no state change.
- Countdown: each edge while busy, counter−1. On the edge where counter goes 1→0, hi/lo←pending, md_busy←0.
- Operand capture occurs only at accept; later changes on src_a/src_b do not affect the in-flight result.
- Reset mid-operation: operation discarded, hi/lo=0, md_busy=0.

## Timing
- Accept at edge k: md_busy high from after edge k through edge k+N (N = MUL_CYCLES or DIV_CYCLES), i.e. exactly N cycles.
- hi/lo show the new result after edge k+N, same edge md_busy falls; MFHI/MFLO issued in the next cycle read correct data.
- New start accepted at edge k+N+1 at the earliest (back-to-back requires md_busy=0 sampled).
- MTHI/MTLO: one-cycle, visible after the accept edge.
- md_stall asserts combinationally in the accept cycle (md_busy still 0) so ID stalls before busy rises.
- No combinational path from src_a/src_b to any output.

## Structure
- md_pkg: md_op encodings (NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6) and helper is_md_long(op).
- Sub-module muldiv_core: combinational product/quotient/remainder for a given op and operands, with div-by-zero flag; ex_muldiv holds the counter, pending registers, HI/LO and stall logic.
- Opcode decode of the raw instruction into md_op/md_start stays in CTRL.

## Test plan
- Reset released, MULT src_a=−3 (0xFFFFFFFD), src_b=7 -> md_busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU 0xFFFFFFFF×0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- DIV −7÷2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7÷0 -> busy 10 cycles, hi/lo unchanged.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles -> hi/lo updated one edge each, md_busy stays 0, md_stall 0.
- DIV accepted, md_start+MULT asserted during busy -> ignored, md_stall held high, only DIV result commits; DIV 0x80000000÷−1 -> lo=0x80000000, hi=0.
- MULT accepted, reset pulsed low at busy cycle 3 -> hi=lo=0, md_busy=0 immediately (async), no later commit.

Source files
------------

// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the EX-stage multiply/divide unit.
//   md_op_e    : operation codes driven by CTRL into EX.
//   md_state_e : busy-tracking state of ex_muldiv.
//   is_md_long : true for the multi-cycle ops that occupy the unit.
package md_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    function automatic logic is_md_long(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: EX <-> multiply/divide unit bundle.
//   md_start/md_op/src_a/src_b : request from EX (master drives)
//   md_busy/md_stall           : occupancy indication to the hazard unit
//   hi/lo                      : architectural HI/LO for MFHI/MFLO
interface ex_muldiv_if
    import md_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             md_start;
    md_op_e           md_op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             md_busy;
    logic             md_stall;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output md_start, md_op, src_a, src_b,
        input  md_busy, md_stall, hi, lo
    );

    modport slave (
        input  md_start, md_op, src_a, src_b,
        output md_busy, md_stall, hi, lo
    );
endinterface

// File: rtl/muldiv_core.sv
// muldiv_core: purely combinational arithmetic for ex_muldiv.
//   op       : operation (only MULT/MULTU/DIV/DIVU produce a result)
//   a, b     : operands (a = rs/dividend, b = rt/divisor)
//   res_hi   : product high half, or remainder
//   res_lo   : product low half, or quotient
//   div_zero : DIV/DIVU with b == 0; result must not be committed
module muldiv_core
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  md_op_e           op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             div_zero
);

    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     mag_a, mag_b, div_b, quo, rem;
    logic [2*WIDTH-1:0]   prod;

    // Signed division is done on magnitudes and the signs re-applied.
    // This gives truncation toward zero, a remainder carrying the
    // dividend's sign, and makes MIN / -1 wrap to MIN with remainder 0
    // without any special case.
    always_comb begin
        div_zero = ((op == MD_DIV) || (op == MD_DIVU)) && (b == '0);
        a_neg    = (op == MD_DIV) && a[WIDTH-1];
        b_neg    = (op == MD_DIV) && b[WIDTH-1];
        mag_a    = a_neg ? -a : a;
        mag_b    = b_neg ? -b : b;
        // keep the divider defined when dividing by zero; result is dropped
        div_b    = div_zero ? WIDTH'(1) : mag_b;
        quo      = mag_a / div_b;
        rem      = mag_a % div_b;
        prod     = '0;
        res_hi   = '0;
        res_lo   = '0;
        case (op)
            MD_MULT: begin
                prod = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
                {res_hi, res_lo} = prod;
            end
            MD_MULTU: begin
                prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
                {res_hi, res_lo} = prod;
            end
            MD_DIV, MD_DIVU: begin
                res_lo = (a_neg ^ b_neg) ? -quo : quo;
                res_hi = a_neg ? -rem : rem;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: EX-stage multiply/divide unit owning HI/LO.
//   clk   : pipeline clock, rising edge
//   reset : asynchronous, active low; clears HI/LO and any in-flight op
//   md    : ex_muldiv_if.slave
//           md_start/md_op/src_a/src_b in; md_busy (registered),
//           md_stall (combinational), hi/lo (registered) out.
// Long ops compute their result at accept and hold it in pending
// registers; a countdown models the fixed latency before HI/LO commit.
module ex_muldiv
    import md_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10,
    parameter int CNT_W      = $clog2(((MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES) + 1)
) (
    input  logic          clk,
    input  logic          reset,
    ex_muldiv_if.slave    md
);

    md_state_e        state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hi_q, lo_q, pend_hi, pend_lo;
    logic             pend_we;
    logic [WIDTH-1:0] core_hi, core_lo;
    logic             core_dz;
    logic             accept, accept_long, last_cyc, op_is_div;

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .op       (md.md_op),
        .a        (md.src_a),
        .b        (md.src_b),
        .res_hi   (core_hi),
        .res_lo   (core_lo),
        .div_zero (core_dz)
    );

    // starts arriving while busy are ignored outright
    assign accept      = md.md_start && (state == ST_IDLE);
    assign accept_long = accept && is_md_long(md.md_op);
    assign last_cyc    = (state == ST_BUSY) && (cnt == CNT_W'(1));
    assign op_is_div   = (md.md_op == MD_DIV) || (md.md_op == MD_DIVU);

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept_long) state_nxt = ST_BUSY;
            ST_BUSY: if (last_cyc)    state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // outputs: stall covers the accept cycle, before busy has risen
    always_comb begin
        md.md_busy  = (state == ST_BUSY);
        md.md_stall = (state == ST_BUSY) || (md.md_start && is_md_long(md.md_op));
    end

    // countdown, pending result and architectural HI/LO
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_we <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            if (accept_long) begin
                cnt     <= op_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
                pend_hi <= core_hi;
                pend_lo <= core_lo;
                pend_we <= !core_dz;
            end else if (state == ST_BUSY) begin
                cnt <= cnt - CNT_W'(1);
                if (last_cyc && pend_we) begin
                    hi_q <= pend_hi;
                    lo_q <= pend_lo;
                end
            end
            // moves only happen from idle, so they never collide with a commit
            if (accept && (md.md_op == MD_MTHI)) hi_q <= md.src_a;
            if (accept && (md.md_op == MD_MTLO)) lo_q <= md.src_a;
        end
    end

    assign md.hi = hi_q;
    assign md.lo = lo_q;

endmodule
